multicycle_main_fsm: RTL and testbench
======================================

// Module: multicycle_main_fsm
// PURPOSE
//  Parametrised multi-cycle successor to the single-cycle main decoder. A Moore FSM that sequences
//  fetch/decode/execute/memory/writeback per instruction and drives datapath controls.
//  Adds a memory req/ready handshake, a wait timeout, an illegal-opcode trap and a retired-
//  instruction counter. Sits between the instruction register and the shared-memory multicycle datapath.
// PARAMETERS
//  MEM_TIMEOUT  15  max wait cycles per memory access before trap; 0 = no timeout
//  CNT_W        32  width of instret counter
//  EN_ITYPE     1   1 = decode OP-IMM (0010011); 0 = treat as illegal
//  EN_JAL       1   1 = decode JAL (1101111); 0 = treat as illegal
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  Op         in   7      opcode from instruction register
//  zero       in   1      ALU zero flag
//  mem_ready  in   1      memory completes current access this cycle
//  mem_req    out  1      memory access request
//  PCWrite    out  1      PC load enable = PCUpdate | (Branch & zero)
//  AdrSrc     out  1      0 = PC, 1 = ALU result as memory address
//  MemWrite   out  1      memory write strobe
//  IRWrite    out  1      instruction register load
//  RegWrite   out  1      register file write
//  ResultSrc  out  2      00 ALUOut, 01 mem data, 10 ALU result
//  ALUSrcA    out  2      00 PC, 01 OldPC, 10 rs1
//  ALUSrcB    out  2      00 rs2, 01 imm, 10 const 4
//  ALUOp      out  2      00 add, 01 sub (branch), 10 funct-decoded
//  ImmSrc     out  2      00 I, 01 S, 10 B, 11 J; combinational from Op
//  Branch     out  1      high in BEQ state only
//  trap       out  1      sticky: illegal opcode or memory timeout
//  mem_err    out  1      sticky: trap was caused by timeout
//  instret    out  CNT_W  count of retired instructions
// BEHAVIOUR
//  Reset: state<=FETCH, wait counter, instret, trap and mem_err <= 0. All outputs are 0 while rst
//   is high. FETCH outputs start the cycle after rst falls. Reset mid-access abandons it.
//  All controls not listed for a state are 0.
//  FETCH: mem_req=1, AdrSrc=0, SrcA=00, SrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCUpdate=mem_ready.
//   Go to DECODE on mem_ready, else hold.
//  DECODE: SrcA=01, SrcB=01, ALUOp=00. Next state from Op:
//   0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BEQ,
//   1101111 -> JAL. Anything else, or a disabled op -> TRAP.
//  MEMADR: SrcA=10, SrcB=01, ALUOp=00. Go to MEMRD if Op=0000011, else MEMWR.
//  MEMRD: mem_req=1, AdrSrc=1. Go to MEMWB on mem_ready.
//  MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
//  MEMWR: mem_req=1, AdrSrc=1, MemWrite=1. Go to FETCH on mem_ready.
//  EXECR: SrcA=10, SrcB=00, ALUOp=10. Go to ALUWB.
//  EXECI: SrcA=10, SrcB=01, ALUOp=10. Go to ALUWB.
//  ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
//  BEQ: SrcA=10, SrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Go to FETCH.
//  JAL: SrcA=01, SrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Go to ALUWB.
//  TRAP: absorbing. All controls 0, trap=1. Exit only by rst.
//  Timeout: wait counter clears on entry to FETCH/MEMRD/MEMWR and increments each cycle with
//   mem_req=1 and mem_ready=0. If it reaches MEM_TIMEOUT with mem_ready=0 -> TRAP, mem_err=1.
//   mem_ready in the same cycle wins over timeout.
//  instret: +1 on every transition into FETCH from MEMWB, MEMWR, ALUWB or BEQ. Wraps mod 2^CNT_W.
//  Latency in cycles: lw 5, sw 4, R/I 4, beq 3, jal 4, each with zero-wait memory.
//  mem_ready outside mem_req states is ignored.
// TESTING
//  rst=1 for 2 cycles, then 0, mem_ready=1 -> all outputs 0 during reset; FETCH has mem_req=1, IRWrite=1, PCWrite=1.
//  lw (Op=0000011), 3-cycle read wait -> state path FETCH,DECODE,MEMADR,MEMRD x3,MEMWB; RegWrite=1 only in MEMWB; instret 0->1.
//  beq with zero=1, then zero=0 -> PCWrite=1 in BEQ in the first case only; instret +1 each.
//  Op=1110011, and Op=0010011 with EN_ITYPE=0 -> TRAP, trap=1 and held, mem_err=0; rst clears it.
//  MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after 4 wait cycles, mem_err=1, mem_req=0.
//  CNT_W=3, 9 R-type instructions -> instret=1 (wrap); rst asserted during MEMWR -> MemWrite=0 the next cycle.

Source files
------------

// File: rtl/multicycle_main_fsm.sv
// Moore control FSM for a shared-memory multicycle RISC-V datapath: sequences each instruction
// through fetch/decode/execute/memory/writeback, with memory handshake, timeout and illegal-op trap.
module multicycle_main_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32,
  parameter int EN_ITYPE    = 1,
  parameter int EN_JAL      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       Op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ImmSrc,
  output logic             Branch,
  output logic             trap,
  output logic             mem_err,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // The wait counter only needs to reach MEM_TIMEOUT-1; the trap fires on that cycle.
  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]  r_instret;
  logic              r_mem_err;

  logic       w_mem_req, w_pc_update, w_adr_src, w_mem_write, w_ir_write, w_reg_write, w_branch;
  logic [1:0] w_result_src, w_alu_src_a, w_alu_src_b, w_alu_op, w_imm_src;
  logic       w_wait_expired, w_timeout_trap, w_retire;

  assign w_wait_expired = (MEM_TIMEOUT != 0) && (r_wait_cnt == WAIT_LAST) && !mem_ready;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    w_next         = r_state;
    w_mem_req      = 1'b0;
    w_pc_update    = 1'b0;
    w_adr_src      = 1'b0;
    w_mem_write    = 1'b0;
    w_ir_write     = 1'b0;
    w_reg_write    = 1'b0;
    w_branch       = 1'b0;
    w_result_src   = 2'b00;
    w_alu_src_a    = 2'b00;
    w_alu_src_b    = 2'b00;
    w_alu_op       = 2'b00;
    w_timeout_trap = 1'b0;
    case (Op)
      OP_STORE:  w_imm_src = 2'b01;
      OP_BRANCH: w_imm_src = 2'b10;
      OP_JAL:    w_imm_src = 2'b11;
      default:   w_imm_src = 2'b00;
    endcase

    unique case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = mem_ready;
        w_pc_update  = mem_ready;
        if (mem_ready) w_next = S_DECODE;
        else if (w_wait_expired) begin
          w_next         = S_TRAP;
          w_timeout_trap = 1'b1;
        end
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        case (Op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = (EN_ITYPE != 0) ? S_EXECI : S_TRAP;
          OP_BRANCH:         w_next = S_BEQ;
          OP_JAL:            w_next = (EN_JAL != 0) ? S_JAL : S_TRAP;
          default:           w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_next      = (Op == OP_LOAD) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
        else if (w_wait_expired) begin
          w_next         = S_TRAP;
          w_timeout_trap = 1'b1;
        end
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWR: begin
        w_mem_req   = 1'b1;
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        if (mem_ready) w_next = S_FETCH;
        else if (w_wait_expired) begin
          w_next         = S_TRAP;
          w_timeout_trap = 1'b1;
        end
      end
      S_EXECR: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b10;
        w_next      = S_ALUWB;
      end
      S_EXECI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b10;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BEQ: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b01;
        w_branch    = 1'b1;
        w_next      = S_FETCH;
      end
      S_JAL: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_update = 1'b1;
        w_next      = S_ALUWB;
      end
      S_TRAP: begin
        w_imm_src = 2'b00;
        w_next    = S_TRAP;
      end
      default: w_next = S_TRAP;
    endcase
  end

  assign w_retire = (w_next == S_FETCH) &&
                    (r_state inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BEQ});

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_instret  <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_wait_cnt <= '0;
      else if (w_mem_req && !mem_ready && (MEM_TIMEOUT != 0)) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      if (w_retire)       r_instret <= r_instret + CNT_W'(1);
      if (w_timeout_trap) r_mem_err <= 1'b1;
    end
  end

  // Outputs are forced low for the whole time rst is high, including the first cycle.
  assign mem_req   = w_mem_req & ~rst;
  assign PCWrite   = (w_pc_update | (w_branch & zero)) & ~rst;
  assign AdrSrc    = w_adr_src & ~rst;
  assign MemWrite  = w_mem_write & ~rst;
  assign IRWrite   = w_ir_write & ~rst;
  assign RegWrite  = w_reg_write & ~rst;
  assign Branch    = w_branch & ~rst;
  assign ResultSrc = rst ? 2'b00 : w_result_src;
  assign ALUSrcA   = rst ? 2'b00 : w_alu_src_a;
  assign ALUSrcB   = rst ? 2'b00 : w_alu_src_b;
  assign ALUOp     = rst ? 2'b00 : w_alu_op;
  assign ImmSrc    = rst ? 2'b00 : w_imm_src;
  assign trap      = (r_state == S_TRAP) & ~rst;
  assign mem_err   = r_mem_err & ~rst;
  assign instret   = rst ? '0 : r_instret;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm: a default-parameter instance driven by a vector table,
// plus a small-parameter instance for timeout, disabled-op trap, counter wrap and mid-access reset.
module tb_multicycle_main_fsm;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BQ   = 7'b1100011;
  localparam logic [6:0] JL   = 7'b1101111;
  localparam logic [6:0] ILL  = 7'b1110011;

  typedef enum {E_RST, E_F, E_D, E_MA, E_MR, E_MWB, E_MW, E_ER, E_EI, E_AWB, E_BEQ, E_JAL, E_TRAP} est_t;

  typedef struct packed {
    logic       mem_req, pcwrite, adrsrc, memwrite, irwrite, regwrite;
    logic [1:0] resultsrc, srca, srcb, aluop, immsrc;
    logic       branch, trap, mem_err;
  } ctl_t;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        zero;
    logic        rdy;
    est_t        st;
    int unsigned ir;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] op = LW;
  logic zero = 1'b0;
  logic rdy = 1'b1;

  always #5 clk = ~clk;

  logic        a_mem_req, a_pcw, a_adr, a_mw, a_irw, a_rw, a_br, a_trap, a_merr;
  logic [1:0]  a_rs, a_sa, a_sb, a_aop, a_imm;
  logic [31:0] a_instret;
  logic        b_mem_req, b_pcw, b_adr, b_mw, b_irw, b_rw, b_br, b_trap, b_merr;
  logic [1:0]  b_rs, b_sa, b_sb, b_aop, b_imm;
  logic [2:0]  b_instret;

  multicycle_main_fsm u_a (
    .clk(clk), .rst(rst), .Op(op), .zero(zero), .mem_ready(rdy),
    .mem_req(a_mem_req), .PCWrite(a_pcw), .AdrSrc(a_adr), .MemWrite(a_mw), .IRWrite(a_irw),
    .RegWrite(a_rw), .ResultSrc(a_rs), .ALUSrcA(a_sa), .ALUSrcB(a_sb), .ALUOp(a_aop),
    .ImmSrc(a_imm), .Branch(a_br), .trap(a_trap), .mem_err(a_merr), .instret(a_instret)
  );

  multicycle_main_fsm #(.MEM_TIMEOUT(4), .CNT_W(3), .EN_ITYPE(0), .EN_JAL(1)) u_b (
    .clk(clk), .rst(rst), .Op(op), .zero(zero), .mem_ready(rdy),
    .mem_req(b_mem_req), .PCWrite(b_pcw), .AdrSrc(b_adr), .MemWrite(b_mw), .IRWrite(b_irw),
    .RegWrite(b_rw), .ResultSrc(b_rs), .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ALUOp(b_aop),
    .ImmSrc(b_imm), .Branch(b_br), .trap(b_trap), .mem_err(b_merr), .instret(b_instret)
  );

  ctl_t a_act, b_act;
  assign a_act = {a_mem_req, a_pcw, a_adr, a_mw, a_irw, a_rw, a_rs, a_sa, a_sb, a_aop, a_imm,
                  a_br, a_trap, a_merr};
  assign b_act = {b_mem_req, b_pcw, b_adr, b_mw, b_irw, b_rw, b_rs, b_sa, b_sb, b_aop, b_imm,
                  b_br, b_trap, b_merr};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected control word for a state, built from the per-state control table.
  function automatic ctl_t model(input est_t st, input logic [6:0] o, input logic z,
                                 input logic r, input logic merr);
    ctl_t c;
    c = '0;
    if (st != E_RST && st != E_TRAP) begin
      if (o == SW)      c.immsrc = 2'b01;
      else if (o == BQ) c.immsrc = 2'b10;
      else if (o == JL) c.immsrc = 2'b11;
    end
    case (st)
      E_F:    begin c.mem_req = 1'b1; c.srcb = 2'b10; c.resultsrc = 2'b10; c.irwrite = r; c.pcwrite = r; end
      E_D:    begin c.srca = 2'b01; c.srcb = 2'b01; end
      E_MA:   begin c.srca = 2'b10; c.srcb = 2'b01; end
      E_MR:   begin c.mem_req = 1'b1; c.adrsrc = 1'b1; end
      E_MWB:  begin c.resultsrc = 2'b01; c.regwrite = 1'b1; end
      E_MW:   begin c.mem_req = 1'b1; c.adrsrc = 1'b1; c.memwrite = 1'b1; end
      E_ER:   begin c.srca = 2'b10; c.aluop = 2'b10; end
      E_EI:   begin c.srca = 2'b10; c.srcb = 2'b01; c.aluop = 2'b10; end
      E_AWB:  c.regwrite = 1'b1;
      E_BEQ:  begin c.srca = 2'b10; c.aluop = 2'b01; c.branch = 1'b1; c.pcwrite = z; end
      E_JAL:  begin c.srca = 2'b01; c.srcb = 2'b10; c.pcwrite = 1'b1; end
      E_TRAP: begin c.trap = 1'b1; c.mem_err = merr; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic vec_t mk(input logic r, input logic [6:0] o, input logic z, input logic y,
                              input est_t st, input int unsigned ir);
    vec_t v;
    v.rst = r; v.op = o; v.zero = z; v.rdy = y; v.st = st; v.ir = ir;
    return v;
  endfunction

  task automatic drive(input logic r, input logic [6:0] o, input logic z, input logic y);
    @(negedge clk);
    rst = r; op = o; zero = z; rdy = y;
    #1;
  endtask

  task automatic check_b(input string name, input est_t st, input logic merr);
    check(name, 64'(b_act), 64'(model(st, op, zero, rdy, merr)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    vecs.push_back(mk(1, LW, 0, 1, E_RST, 0));
    vecs.push_back(mk(1, LW, 0, 1, E_RST, 0));
    vecs.push_back(mk(0, LW, 0, 1, E_F,   0));
    vecs.push_back(mk(0, LW, 1, 1, E_D,   0));
    vecs.push_back(mk(0, LW, 0, 0, E_MA,  0));
    vecs.push_back(mk(0, LW, 0, 0, E_MR,  0));
    vecs.push_back(mk(0, LW, 0, 0, E_MR,  0));
    vecs.push_back(mk(0, LW, 0, 1, E_MR,  0));
    vecs.push_back(mk(0, LW, 0, 1, E_MWB, 0));
    vecs.push_back(mk(0, SW, 0, 1, E_F,   1));
    vecs.push_back(mk(0, SW, 0, 1, E_D,   1));
    vecs.push_back(mk(0, SW, 0, 1, E_MA,  1));
    vecs.push_back(mk(0, SW, 0, 1, E_MW,  1));
    vecs.push_back(mk(0, BQ, 1, 1, E_F,   2));
    vecs.push_back(mk(0, BQ, 1, 1, E_D,   2));
    vecs.push_back(mk(0, BQ, 1, 1, E_BEQ, 2));
    vecs.push_back(mk(0, BQ, 0, 1, E_F,   3));
    vecs.push_back(mk(0, BQ, 0, 1, E_D,   3));
    vecs.push_back(mk(0, BQ, 0, 1, E_BEQ, 3));
    vecs.push_back(mk(0, IT, 0, 1, E_F,   4));
    vecs.push_back(mk(0, IT, 0, 0, E_D,   4));
    vecs.push_back(mk(0, IT, 0, 0, E_EI,  4));
    vecs.push_back(mk(0, IT, 1, 0, E_AWB, 4));
    vecs.push_back(mk(0, JL, 0, 1, E_F,   5));
    vecs.push_back(mk(0, JL, 0, 1, E_D,   5));
    vecs.push_back(mk(0, JL, 0, 1, E_JAL, 5));
    vecs.push_back(mk(0, JL, 0, 1, E_AWB, 5));
    vecs.push_back(mk(0, RT, 0, 0, E_F,   6));
    vecs.push_back(mk(0, RT, 0, 1, E_F,   6));
    vecs.push_back(mk(0, RT, 0, 0, E_D,   6));
    vecs.push_back(mk(0, RT, 0, 1, E_ER,  6));
    vecs.push_back(mk(0, RT, 0, 1, E_AWB, 6));
    vecs.push_back(mk(0, ILL, 0, 1, E_F,  7));
    vecs.push_back(mk(0, ILL, 0, 1, E_D,  7));
    vecs.push_back(mk(0, ILL, 0, 1, E_TRAP, 7));
    vecs.push_back(mk(0, ILL, 1, 1, E_TRAP, 7));
    vecs.push_back(mk(1, ILL, 0, 1, E_RST, 0));
    vecs.push_back(mk(0, LW, 0, 1, E_F,   0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].op, vecs[i].zero, vecs[i].rdy);
      check($sformatf("vec%0d ctl", i), 64'(a_act),
            64'(model(vecs[i].st, vecs[i].op, vecs[i].zero, vecs[i].rdy, 1'b0)));
      check($sformatf("vec%0d instret", i), 64'(a_instret), 64'(vecs[i].ir));
    end

    // OP-IMM disabled on instance B: decodes to TRAP, trap sticky, mem_err clear.
    drive(1, IT, 0, 1);
    drive(1, IT, 0, 1);  check_b("b_rst", E_RST, 1'b0);
    drive(0, IT, 0, 1);  check_b("b_itype_fetch", E_F, 1'b0);
    drive(0, IT, 0, 1);  check_b("b_itype_decode", E_D, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(0, IT, 0, 1); check_b($sformatf("b_itype_trap%0d", k), E_TRAP, 1'b0);
    end
    drive(1, IT, 0, 1);  check_b("b_trap_rst", E_RST, 1'b0);
    drive(0, RT, 0, 1);  check_b("b_trap_cleared", E_F, 1'b0);

    // Timeout: four wait cycles in FETCH then TRAP with mem_err; A (limit 15) keeps waiting.
    drive(1, RT, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(0, RT, 0, 0); check_b($sformatf("b_wait%0d", k), E_F, 1'b0);
    end
    drive(0, RT, 0, 0);  check_b("b_timeout_trap", E_TRAP, 1'b1);
    check("a_no_timeout", 64'(a_act), 64'(model(E_F, RT, 1'b0, 1'b0, 1'b0)));
    drive(0, RT, 0, 1);  check_b("b_timeout_held", E_TRAP, 1'b1);

    // mem_ready on the last allowed wait cycle wins over the timeout.
    drive(1, RT, 0, 0);
    for (int k = 0; k < 3; k++) drive(0, RT, 0, 0);
    drive(0, RT, 0, 1);  check_b("b_ready_wins", E_F, 1'b0);
    drive(0, RT, 0, 1);  check_b("b_ready_wins_decode", E_D, 1'b0);

    // 3-bit instret wraps after 8 retirements.
    drive(1, RT, 0, 1);
    for (int n = 0; n < 9; n++) begin
      drive(0, RT, 0, 1);
      check_b($sformatf("wrap%0d_f", n), E_F, 1'b0);
      check($sformatf("wrap%0d_instret", n), 64'(b_instret), 64'(n % 8));
      drive(0, RT, 0, 1); check_b($sformatf("wrap%0d_d", n), E_D, 1'b0);
      drive(0, RT, 0, 1); check_b($sformatf("wrap%0d_er", n), E_ER, 1'b0);
      drive(0, RT, 0, 1); check_b($sformatf("wrap%0d_wb", n), E_AWB, 1'b0);
    end
    drive(0, RT, 0, 1);
    check("wrap_final_instret", 64'(b_instret), 64'd1);

    // Reset in the middle of a store abandons it.
    drive(1, SW, 0, 1);
    drive(0, SW, 0, 1);  check_b("sw_fetch", E_F, 1'b0);
    drive(0, SW, 0, 1);  check_b("sw_decode", E_D, 1'b0);
    drive(0, SW, 0, 0);  check_b("sw_memadr", E_MA, 1'b0);
    drive(0, SW, 0, 0);  check_b("sw_memwr", E_MW, 1'b0);
    drive(1, SW, 0, 0);  check_b("sw_rst_during_memwr", E_RST, 1'b0);
    drive(0, SW, 0, 0);  check_b("sw_after_rst", E_F, 1'b0);
    check("sw_after_rst_memwrite", 64'(b_mw), 64'd0);
    check("sw_after_rst_instret", 64'(b_instret), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
